// File: rtl/tms_wb_rom_loader.sv
// Wishbone slave that streams ROM bytes through a small FIFO into the TMS1x00 ROM write port and gates core reset.
// Optional parity on the ROM write path is enabled by defining TMS_ROM_PARITY_EN.
module tms_wb_rom_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROM_AW     = 11,
    parameter int unsigned ROM_DW     = 8
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [ROM_DW-1:0] rom_wdata,
    input  logic              rom_ack,
`ifdef TMS_ROM_PARITY_EN
    output logic              rom_wpar,
`endif
    output logic              core_rst_n
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef TMS_ROM_PARITY_EN
    localparam int unsigned EW      = ROM_AW + ROM_DW + 1;
    localparam logic        PAR_BIT = 1'b1;
`else
    localparam int unsigned EW      = ROM_AW + ROM_DW;
    localparam logic        PAR_BIT = 1'b0;
`endif
    localparam logic [ROM_AW-1:0] ADDR_ONE = 1;

    typedef enum logic {S_IDLE, S_WRITE} state_e;

    state_e              state_q, state_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;
    logic                run_q, stalled_q, ack_q, core_rst_n_q;
    logic [31:0]         dat_q, rdata;
    logic [ROM_AW-1:0]   naddr_q;
    logic                rom_we_q, rom_we_d;
    logic [EW-1:0]       out_q, out_d;
    logic                empty, full, sel, stall, accept, wr, push, pop, flush;
    logic [1:0]          off;
    logic [EW-1:0]       push_entry;
    logic [31:0]         status;
    logic                unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_dat_i};

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign off   = wbs_adr_i[3:2];

    // ack_q gating forces a dead cycle between back-to-back acks
    assign sel    = wbs_cyc_i & wbs_stb_i & ~ack_q
                  & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & (wbs_adr_i[1:0] == 2'b00);
    assign stall  = sel & wbs_we_i & (off == 2'd3) & full;
    assign accept = sel & ~stall;
    assign wr     = accept & wbs_we_i;
    assign flush  = wr & (off == 2'd0) & wbs_dat_i[1];
    assign push   = wr & (off == 2'd3);

`ifdef TMS_ROM_PARITY_EN
    assign push_entry = {^wbs_dat_i[ROM_DW-1:0], naddr_q, wbs_dat_i[ROM_DW-1:0]};
`else
    assign push_entry = {naddr_q, wbs_dat_i[ROM_DW-1:0]};
`endif

    assign status = {14'b0, PAR_BIT, stalled_q, 8'(cnt_q), 5'b0,
                     (state_q != S_IDLE), full, empty};

    always_comb begin
        rdata = '0;
        case (off)
            2'd0:    rdata = {31'b0, run_q};
            2'd1:    rdata = status;
            2'd2:    rdata = 32'(naddr_q);
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rom_we_d = rom_we_q;
        out_d    = out_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    out_d    = mem_q[rd_q];
                    rom_we_d = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (rom_ack) begin
                    if (!empty) begin
                        pop   = 1'b1;
                        out_d = mem_q[rd_q];
                    end else begin
                        rom_we_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_q] <= push_entry;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            stalled_q    <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            naddr_q      <= '0;
            rom_we_q     <= 1'b0;
            out_q        <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_we_q     <= rom_we_d;
            out_q        <= out_d;
            ack_q        <= accept;
            dat_q        <= (accept && !wbs_we_i) ? rdata : '0;
            core_rst_n_q <= run_q & empty & (state_q == S_IDLE);

            // FLUSH overrides any same-edge push/pop on the pointers
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + PW'(1);
                if (pop)  rd_q <= rd_q + PW'(1);
                if (push && !pop)      cnt_q <= cnt_q + CW'(1);
                else if (pop && !push) cnt_q <= cnt_q - CW'(1);
            end

            if (stall) stalled_q <= 1'b1;
            else if (wr && off == 2'd1 && wbs_dat_i[16]) stalled_q <= 1'b0;

            if (wr && off == 2'd0) run_q <= wbs_dat_i[0];
            if (wr && off == 2'd2) naddr_q <= wbs_dat_i[ROM_AW-1:0];
            else if (push)         naddr_q <= naddr_q + ADDR_ONE;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign rom_we     = rom_we_q;
    assign rom_wdata  = out_q[ROM_DW-1:0];
    assign rom_addr   = out_q[ROM_DW +: ROM_AW];
    assign core_rst_n = core_rst_n_q;
`ifdef TMS_ROM_PARITY_EN
    assign rom_wpar   = out_q[EW-1];
`endif

endmodule

// File: tb/tb_tms_wb_rom_loader.sv
// Self-checking bench for tms_wb_rom_loader: register access, streaming, backpressure, wrap, RUN gating, FLUSH, reset.
module tb_tms_wb_rom_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_ADDR = BASE + 32'h8;
    localparam logic [31:0] A_DATA = BASE + 32'hC;
`ifdef TMS_ROM_PARITY_EN
    localparam logic [31:0] PBIT = 32'h0002_0000;
`else
    localparam logic [31:0] PBIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_w;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        rom_we;
    logic [10:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic        rom_ack;
    logic        core_rst_n;
`ifdef TMS_ROM_PARITY_EN
    logic        rom_wpar;
`endif

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [10:0] tb_addr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tms_wb_rom_loader #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(4),
        .ROM_AW    (11),
        .ROM_DW    (8)
    ) dut (
        .wb_clk_i  (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc),
        .wbs_stb_i (wbs_stb),
        .wbs_we_i  (wbs_we),
        .wbs_sel_i (wbs_sel),
        .wbs_adr_i (wbs_adr),
        .wbs_dat_i (wbs_dat_w),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .rom_ack   (rom_ack),
`ifdef TMS_ROM_PARITY_EN
        .rom_wpar  (rom_wpar),
`endif
        .core_rst_n(core_rst_n)
    );

    // ROM write scoreboard: every accepted ROM write must match the oldest expected push
    always @(negedge clk) begin
        if (rst_n && rom_we && rom_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rom_write unexpected: addr=%h data=%h, none expected", rom_addr, rom_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rom_addr !== mon_e.a || rom_wdata !== mon_e.d) begin
                    errors++;
                    $display("FAIL rom_write: got addr=%h data=%h, expected addr=%h data=%h",
                             rom_addr, rom_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int maxcyc, output logic acked, output logic [31:0] rdata);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat_w = dat;
        acked = 1'b0; rdata = '0;
        for (int i = 0; i < maxcyc && !acked; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdata = wbs_dat_o;
            end
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
        logic        ok;
        logic [31:0] rd;
        exp_t        e;
        wb_cycle(1'b1, adr, dat, 20, ok, rd);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL bus_write_timeout: adr=%h no ack within 20 cycles", adr);
        end else if (adr == A_ADDR) begin
            tb_addr = dat[10:0];
        end else if (adr == A_DATA) begin
            e.a = tb_addr; e.d = dat[7:0];
            exp_q.push_back(e);
            tb_addr = tb_addr + 11'd1;
        end
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
        logic ok;
        wb_cycle(1'b0, adr, '0, 20, ok, rd);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL bus_read_timeout: adr=%h no ack within 20 cycles", adr);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst_n = 1'b0; rom_ack = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        exp_q.delete(); tb_addr = '0;
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_bus: ack=%b dat=%h, expected ack=0 dat=0", wbs_ack_o, wbs_dat_o);
        end
        checks++;
        if (rom_we !== 1'b0 || rom_addr !== 11'h0 || rom_wdata !== 8'h0 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_rom: we=%b addr=%h data=%h core_rst_n=%b, expected all 0",
                     rom_we, rom_addr, rom_wdata, core_rst_n);
        end
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h1 | PBIT)) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h1 | PBIT); end
        wb_rd(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
        wb_rd(A_ADDR, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_romaddr: got %h expected 0", rd); end
    endtask

    task automatic test_stream;
        logic [31:0] rd;
        rom_ack = 1'b1;
        wb_wr(A_ADDR, 32'h010);
        wb_wr(A_DATA, 32'hA5);
        wb_wr(A_DATA, 32'h3C);
        wait_cycles(6);
        wb_rd(A_ADDR, rd);
        checks++;
        if (rd !== 32'h012) begin errors++; $display("FAIL stream_romaddr: got %h expected 012", rd); end
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h1 | PBIT)) begin errors++; $display("FAIL stream_status: got %h expected %h", rd, 32'h1 | PBIT); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d writes missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_unmapped;
        logic        ok;
        logic [31:0] rd;
        wb_cycle(1'b0, BASE + 32'h10, '0, 5, ok, rd);
        checks++;
        if (ok !== 1'b0) begin errors++; $display("FAIL unmapped_ack: got ack=%b expected no ack", ok); end
        wb_cycle(1'b0, A_DATA, '0, 5, ok, rd);
        checks++;
        if (ok !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL romdata_read: ack=%b data=%h, expected ack=1 data=0", ok, rd);
        end
    endtask

    task automatic test_stall;
        logic [31:0] rd;
        logic        early;
        exp_t        e;
        rom_ack = 1'b0;
        wb_wr(A_ADDR, 32'h100);
        for (int i = 0; i < 5; i++) wb_wr(A_DATA, 32'h11 + i);
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h0406 | PBIT)) begin errors++; $display("FAIL stall_full_status: got %h expected %h", rd, 32'h0406 | PBIT); end

        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = A_DATA; wbs_dat_w = 32'h16;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL stall_hold: got ack while full, expected none"); end
        rom_ack = 1'b1;
        @(posedge clk); #1;
        rom_ack = 1'b0;
        checks++;
        if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL stall_ack_early: got ack=%b on slot-free edge, expected 0", wbs_ack_o); end
        @(posedge clk); #1;
        checks++;
        if (wbs_ack_o !== 1'b1) begin
            errors++; $display("FAIL stall_ack: got ack=%b the cycle after slot freed, expected 1", wbs_ack_o);
        end else begin
            e.a = tb_addr; e.d = 8'h16;
            exp_q.push_back(e);
            tb_addr = tb_addr + 11'd1;
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;

        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h0001_0406 | PBIT)) begin
            errors++; $display("FAIL stall_sticky: got %h expected %h", rd, 32'h0001_0406 | PBIT);
        end
        wb_wr(A_STAT, 32'h0001_0000);
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h0406 | PBIT)) begin errors++; $display("FAIL stall_w1c: got %h expected %h", rd, 32'h0406 | PBIT); end
        rom_ack = 1'b1;
        wait_cycles(10);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d writes missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        logic [31:0] rd;
        rom_ack = 1'b1;
        wb_wr(A_ADDR, 32'h7FF);
        wb_wr(A_DATA, 32'h5A);
        wb_wr(A_DATA, 32'hC3);
        wait_cycles(6);
        wb_rd(A_ADDR, rd);
        checks++;
        if (rd !== 32'h001) begin errors++; $display("FAIL wrap_romaddr: got %h expected 001", rd); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d writes missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_run;
        logic [31:0] rd;
        logic        bad;
        rom_ack = 1'b0;
        wb_wr(A_ADDR, 32'h200);
        for (int i = 0; i < 3; i++) wb_wr(A_DATA, 32'h40 + i);
        wb_wr(A_CTRL, 32'h1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            if (core_rst_n !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL run_pending: core_rst_n rose with data pending, expected 0"); end
        rom_ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_cycles(1);
            checks++;
            if (core_rst_n !== (i == 4)) begin
                errors++; $display("FAIL run_release_c%0d: core_rst_n=%b expected %b", i, core_rst_n, (i == 4));
            end
        end
        wb_rd(A_CTRL, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL run_ctrl: got %h expected 1", rd); end
        wb_wr(A_CTRL, 32'h0);
    endtask

    task automatic test_flush;
        logic [31:0] rd;
        logic        bad;
        rom_ack = 1'b0;
        wb_wr(A_ADDR, 32'h300);
        for (int i = 0; i < 3; i++) wb_wr(A_DATA, 32'h70 + i);
        wb_wr(A_CTRL, 32'h2);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h5 | PBIT)) begin errors++; $display("FAIL flush_status: got %h expected %h", rd, 32'h5 | PBIT); end
        rom_ack = 1'b1;
        wait_cycles(1);
        rom_ack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rom_we !== 1'b0) bad = 1'b1;
            wait_cycles(1);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL flush_no_we: rom_we=1 after flush, expected 0"); end
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h1 | PBIT)) begin errors++; $display("FAIL flush_idle: got %h expected %h", rd, 32'h1 | PBIT); end
        wb_rd(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL flush_ctrl: got %h expected 0", rd); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d writes missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        rom_ack = 1'b0;
        wb_wr(A_ADDR, 32'h050);
        wb_wr(A_DATA, 32'h99);
        wb_wr(A_DATA, 32'h98);
        wait_cycles(1);
        checks++;
        if (rom_we !== 1'b1) begin errors++; $display("FAIL midrst_pre: rom_we=%b expected 1", rom_we); end
        rst_n = 1'b0;
        wait_cycles(1);
        checks++;
        if (rom_we !== 1'b0) begin errors++; $display("FAIL midrst_we: rom_we=%b expected 0", rom_we); end
        rst_n = 1'b1;
        exp_q.delete(); tb_addr = '0;
        wb_rd(A_STAT, rd);
        checks++;
        if (rd !== (32'h1 | PBIT)) begin errors++; $display("FAIL midrst_status: got %h expected %h", rd, 32'h1 | PBIT); end
        wb_rd(A_ADDR, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_romaddr: got %h expected 0", rd); end
    endtask

    initial begin
        rst_n = 1'b0; rom_ack = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        wbs_sel = 4'hF; wbs_adr = '0; wbs_dat_w = '0;
        tb_addr = '0;
        @(posedge clk); #1;
        test_reset;
        test_stream;
        test_unmapped;
        test_stall;
        test_wrap;
        test_run;
        test_flush;
        test_reset_mid;
        wait_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
